// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS-subset controller.
package mc_pkg;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; encodings 12..15 are unreachable
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle produced by the output decoder
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: current state (plus MemReady/Zero qualifiers) -> controls.
module mc_output_decode
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  output ctrl_t              ctrl_o
);

  logic pc_write;
  logic branch;

  // Per-state control decode; unknown encodings fall through to all-zero controls
  always_comb begin
    ctrl_o   = '0;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        pc_write         = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      // Write strobe stays up until memory accepts it
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        branch           = 1'b1;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        pc_write      = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
    ctrl_o.pc_en = pc_write | (branch & zero_i);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset controller: state register, next-state logic and reset masking.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  state_t state_q, state_d;
  state_t dec_state;
  logic   mem_rdy;
  logic   illegal;
  ctrl_t  ctrl;

  assign mem_rdy = (USE_MEM_READY != 0) ? MemReady : 1'b1;

  // State register, synchronous reset back to instruction fetch
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values; enables are masked below
  assign dec_state = reset ? S_FETCH : state_q;

  mc_output_decode #(.STATE_W(STATE_W)) u_dec (
    .state_i     (dec_state),
    .mem_ready_i (mem_rdy),
    .zero_i      (Zero),
    .ctrl_o      (ctrl)
  );

  assign IorD      = ctrl.iord;
  assign PCSrc     = ctrl.pc_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign RegDst    = ctrl.reg_dst;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign MemWrite  = ctrl.mem_write & ~reset;
  assign IRWrite   = ctrl.ir_write  & ~reset;
  assign PCEn      = ctrl.pc_en     & ~reset;
  assign RegWrite  = ctrl.reg_write & ~reset;
  assign IllegalOp = illegal        & ~reset;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: instruction-level step model vs. multicycle_controller.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, Zero, MemReady;
  logic [5:0] Opcode;
  logic       IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_controller #(.USE_MEM_READY(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp), .State(State)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;
  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} ph_t;

  function automatic kind_t classify(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // Zero-wait-state instruction length in cycles
  function automatic int ilen(input kind_t k);
    case (k)
      K_LW:         return 5;
      K_SW, K_R:    return 4;
      K_ADDI:       return 4;
      K_BEQ, K_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  // Which step of the instruction a given cycle index is
  function automatic ph_t phase(input kind_t k, input int s);
    if (s == 0) return P_FETCH;
    if (s == 1) return P_DECODE;
    case (k)
      K_LW:    return (s == 2) ? P_MEMADR : (s == 3) ? P_MEMRD : P_MEMWB;
      K_SW:    return (s == 2) ? P_MEMADR : P_MEMWR;
      K_R:     return (s == 2) ? P_EXEC : P_ALUWB;
      K_ADDI:  return (s == 2) ? P_ADDIEX : P_ADDIWB;
      K_BEQ:   return P_BRANCH;
      default: return P_JUMP;
    endcase
  endfunction

  function automatic logic [3:0] ph_state(input ph_t p);
    case (p)
      P_FETCH:  return S_FETCH;
      P_DECODE: return S_DECODE;
      P_MEMADR: return S_MEMADR;
      P_MEMRD:  return S_MEMRD;
      P_MEMWB:  return S_MEMWB;
      P_MEMWR:  return S_MEMWR;
      P_EXEC:   return S_EXEC;
      P_ALUWB:  return S_ALUWB;
      P_BRANCH: return S_BRANCH;
      P_ADDIEX: return S_ADDIEX;
      P_ADDIWB: return S_ADDIWB;
      default:  return S_JUMP;
    endcase
  endfunction

  // Expected {IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemtoReg,RegWrite,IllegalOp}
  function automatic logic [14:0] exp_ctrl(input ph_t p, input logic mr, input logic z,
                                           input logic rst, input logic ill_op);
    logic iord, mw, irw, pcen, sa, rd, m2r, rw, ill;
    logic [1:0] pcs, sb, aop;
    {iord, mw, irw, pcen, sa, rd, m2r, rw, ill} = '0;
    {pcs, sb, aop} = '0;
    if (rst) sb = 2'b01;
    else begin
      case (p)
        P_FETCH:  begin sb = 2'b01; irw = mr; pcen = mr; end
        P_DECODE: begin sb = 2'b11; ill = ill_op; end
        P_MEMADR: begin sa = 1'b1; sb = 2'b10; end
        P_MEMRD:  iord = 1'b1;
        P_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
        P_MEMWR:  begin iord = 1'b1; mw = 1'b1; end
        P_EXEC:   begin sa = 1'b1; aop = 2'b10; end
        P_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
        P_BRANCH: begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
        P_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
        P_ADDIWB: rw = 1'b1;
        default:  begin pcs = 2'b10; pcen = 1'b1; end
      endcase
    end
    return {iord, mw, irw, pcen, pcs, sa, sb, aop, rd, m2r, rw, ill};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    logic [5:0] op;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    if ($urandom_range(0, 6) != 6) return legal[$urandom_range(0, 5)];
    op = 6'b111111;
    for (int i = 0; i < 8; i++) begin
      op = 6'($urandom_range(0, 63));
      if (classify(op) == K_ILL) return op;
    end
    return 6'b111111;
  endfunction

  int    step;
  bit    known;
  kind_t k;
  ph_t   p;

  initial begin
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = 6'b111111;
    step = 0; known = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      k = classify(Opcode);
      p = phase(k, step);
      chk("ctrl", 32'({IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                       RegDst, MemtoReg, RegWrite, IllegalOp}),
          32'(exp_ctrl(p, MemReady, Zero, reset, k == K_ILL)));
      if (known) chk("state", 32'(State), 32'(ph_state(p)));
      @(posedge clk);
      if (reset) begin
        step  = 0;
        known = 1'b1;
      end else if (!((p == P_FETCH || p == P_MEMRD || p == P_MEMWR) && !MemReady)) begin
        step++;
        if (step >= ilen(k)) step = 0;
      end
      #1;
      reset    = (cyc < 1) ? 1'b1 : ($urandom_range(0, 39) == 0);
      MemReady = ($urandom_range(0, 3) != 0);
      Zero     = 1'($urandom_range(0, 1));
      if (step == 0) Opcode = pick_op();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
